// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared types and helpers for the mux16to8 bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETTLE = 2'd1,
        ARB_GRANT  = 2'd2
    } arb_state_t;

    typedef logic arb_owner_t;

    localparam arb_owner_t OWN_IN1 = 1'b0;
    localparam arb_owner_t OWN_IN2 = 1'b1;

    // Width able to hold the larger of the settle window and the burst cap.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux16to8_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux16to8_arbiter_if
// Description : Requester / consumer handshake and mux control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux16to8_arbiter_if;

    logic req1_valid;
    logic req1_ready;
    logic req2_valid;
    logic req2_ready;
    logic out_ready;
    logic out_valid;
    logic sel;
    logic owner;
    logic busy;

    modport master (
        output req1_valid,
        output req2_valid,
        output out_ready,
        input  req1_ready,
        input  req2_ready,
        input  out_valid,
        input  sel,
        input  owner,
        input  busy
    );

    modport slave (
        input  req1_valid,
        input  req2_valid,
        input  out_ready,
        output req1_ready,
        output req2_ready,
        output out_valid,
        output sel,
        output owner,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/mux_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : mux_settle_timer
// Description : Load / count-down timer flagging the last cycle of the
//               RC settle window after a mux select change.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_settle_timer #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_load,
    output logic      o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(SETTLE_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Done on the final settle cycle so the FSM enters GRANT right after it.
    assign o_done = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mux16to8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux16to8_arbiter
// Description : Round-robin, burst-capped arbiter time-sharing one mux16to8
//               between two requesters, with a settle window after each select
//               change. Control only; data stays in the mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mux16to8_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_BURST  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mux16to8_arbiter_if.slave  bus
);

    localparam int CNT_W = cnt_width(SETTLE_CYC, MAX_BURST);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_owner_t       r_sel;
    arb_owner_t       w_sel_nxt;
    arb_owner_t       r_owner;
    arb_owner_t       w_owner_nxt;
    arb_owner_t       r_last;
    arb_owner_t       w_last_nxt;
    arb_owner_t       w_winner;
    logic [CNT_W-1:0] r_burst;
    logic [CNT_W-1:0] w_burst_nxt;
    logic [CNT_W-1:0] w_burst_inc;
    logic             w_own_valid;
    logic             w_peer_valid;
    logic             w_any_req;
    logic             w_out_valid;
    logic             w_beat;
    logic             w_cap;
    logic             w_tmr_load;
    logic             w_tmr_done;

    assign w_own_valid  = (r_owner == OWN_IN2) ? bus.req2_valid : bus.req1_valid;
    assign w_peer_valid = (r_owner == OWN_IN2) ? bus.req1_valid : bus.req2_valid;
    assign w_any_req    = bus.req1_valid | bus.req2_valid;

    // On a tie the requester that did not move the last beat wins.
    assign w_winner = (bus.req1_valid & bus.req2_valid) ? ~r_last :
                      (bus.req2_valid ? OWN_IN2 : OWN_IN1);

    assign w_out_valid = (r_state == ARB_GRANT) & w_own_valid;
    assign w_beat      = w_out_valid & bus.out_ready;
    assign w_burst_inc = r_burst + CNT_W'(1);
    assign w_cap       = (w_burst_inc == CNT_W'(MAX_BURST));

    mux_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tmr_load),
        .o_done (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_sel   <= OWN_IN1;
            r_owner <= OWN_IN1;
            r_last  <= OWN_IN2;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        w_tmr_load  = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = w_winner;
                    w_burst_nxt = '0;
                    if (w_winner == r_sel) begin
                        w_state_nxt = ARB_GRANT;
                    end else begin
                        w_sel_nxt   = w_winner;
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ARB_SETTLE;
                    end
                end
            end

            ARB_SETTLE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                if (!w_own_valid) begin
                    // sel is left alone so the same owner returns without settling.
                    w_state_nxt = ARB_IDLE;
                end else if (w_beat) begin
                    w_last_nxt = r_owner;
                    if (w_cap) begin
                        w_burst_nxt = '0;
                        if (w_peer_valid) begin
                            w_sel_nxt   = ~r_sel;
                            w_owner_nxt = ~r_owner;
                            w_tmr_load  = 1'b1;
                            w_state_nxt = ARB_SETTLE;
                        end
                    end else begin
                        w_burst_nxt = w_burst_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign bus.out_valid  = w_out_valid;
    assign bus.req1_ready = w_beat & (r_owner == OWN_IN1);
    assign bus.req2_ready = w_beat & (r_owner == OWN_IN2);
    assign bus.sel        = r_sel;
    assign bus.owner      = r_owner;
    assign bus.busy       = (r_state != ARB_IDLE);

endmodule
`default_nettype wire
